// File: rtl/bus_rd_fifo.sv
// First-word-fall-through read FIFO: circular buffer with registered count/flags.
// Define BUS_RD_FIFO_OVF_EN to build the sticky overflow flag (oovf); otherwise oovf is tied low.
module bus_rd_fifo #(
  parameter int unsigned pDATA_WIDTH = 8,
  parameter int unsigned pDEPTH      = 4
) (
  input  logic                       iclk,
  input  logic                       irst_n,
  input  logic                       iwr_en,
  input  logic [pDATA_WIDTH-1:0]     iwr_data,
  output logic                       ofull,
  input  logic                       ird_en,
  output logic [pDATA_WIDTH-1:0]     ord_data,
  output logic                       ovalid,
  output logic [$clog2(pDEPTH):0]    ocount,
  input  logic                       iclr_ovf,
  output logic                       oovf
);

  localparam int unsigned AW = $clog2(pDEPTH);
  localparam int unsigned CW = AW + 1;

  logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full, valid;
  logic                   wr_acc, rd_acc;

  assign full   = (count_q == CW'(pDEPTH));
  assign valid  = (count_q != '0);
  assign ofull  = full;
  assign ovalid = valid;
  assign ocount = count_q;

  // A write into a full FIFO is accepted only because the same-cycle pop frees the head slot.
  assign wr_acc = iwr_en & (~full | ird_en);
  assign rd_acc = ird_en & valid;

  assign ord_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge iclk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= iwr_data;
  end

`ifdef BUS_RD_FIFO_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_set;

  assign ovf_set = iwr_en & full & ~ird_en;

  always_comb begin
    ovf_d = ovf_q;
    if (iclr_ovf) ovf_d = 1'b0;
    if (ovf_set)  ovf_d = 1'b1;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign oovf = ovf_q;
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = iclr_ovf;
  assign oovf = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rd_fifo.sv
// Directed self-checking bench for bus_rd_fifo (pDATA_WIDTH=8, pDEPTH=4).
module tb_bus_rd_fifo;

  logic       iclk = 1'b0;
  logic       irst_n;
  logic       iwr_en;
  logic [7:0] iwr_data;
  logic       ofull;
  logic       ird_en;
  logic [7:0] ord_data;
  logic       ovalid;
  logic [2:0] ocount;
  logic       iclr_ovf;
  logic       oovf;

  int errors = 0;
  int checks = 0;

`ifdef BUS_RD_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  bus_rd_fifo #(.pDATA_WIDTH(8), .pDEPTH(4)) dut (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .iwr_en  (iwr_en),
    .iwr_data(iwr_data),
    .ofull   (ofull),
    .ird_en  (ird_en),
    .ord_data(ord_data),
    .ovalid  (ovalid),
    .ocount  (ocount),
    .iclr_ovf(iclr_ovf),
    .oovf    (oovf)
  );

  always #5 iclk = ~iclk;

  // One clock with the given strobes; returns 1 time unit after the rising edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    iwr_en   = we;
    iwr_data = wd;
    ird_en   = re;
    iclr_ovf = clr;
    @(posedge iclk);
    #1;
    iwr_en   = 1'b0;
    ird_en   = 1'b0;
    iclr_ovf = 1'b0;
  endtask

  task automatic test_reset;
    irst_n = 1'b0; iwr_en = 1'b0; ird_en = 1'b0; iwr_data = '0; iclr_ovf = 1'b0;
    #12;
    checks++; if (ocount !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ocount); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ovalid); end
    checks++; if (ofull !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", ofull); end
    checks++; if (oovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", oovf); end
    irst_n = 1'b1;
    @(posedge iclk); #1;
  endtask

  task automatic test_first_write;
    step(1'b1, 8'h11, 1'b0, 1'b0);
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", ovalid); end
    checks++; if (ord_data !== 8'h11) begin errors++; $display("FAIL first_data got=%h exp=11", ord_data); end
    checks++; if (ocount !== 3'd1) begin errors++; $display("FAIL first_count got=%0d exp=1", ocount); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL first_empty got=%b exp=0", ovalid); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    checks++; if (ofull !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", ofull); end
    checks++; if (ocount !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", ocount); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (ord_data !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, ord_data, 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", ovalid); end
    checks++; if (ocount !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", ocount); end
  endtask

  task automatic test_full_drop;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++; if (ocount !== 3'd4) begin errors++; $display("FAIL drop_count got=%0d exp=4", ocount); end
    checks++; if (ofull !== 1'b1) begin errors++; $display("FAIL drop_full got=%b exp=1", ofull); end
    checks++; if (oovf !== OVF_EXP) begin errors++; $display("FAIL drop_ovf got=%b exp=%b", oovf, OVF_EXP); end
    checks++; if (ord_data !== 8'h21) begin errors++; $display("FAIL drop_head got=%h exp=21", ord_data); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (oovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", oovf); end
    // Simultaneous set and clear must leave the flag set.
    step(1'b1, 8'hAB, 1'b0, 1'b1);
    checks++; if (oovf !== OVF_EXP) begin errors++; $display("FAIL ovf_setclr got=%b exp=%b", oovf, OVF_EXP); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ord_data !== 8'h21 + 8'(i)) begin errors++; $display("FAIL drop_drain[%0d] got=%h exp=%h", i, ord_data, 8'h21 + 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL drop_empty got=%b exp=0", ovalid); end
  endtask

  task automatic test_full_simul;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h32; exp_q[1] = 8'h33; exp_q[2] = 8'h34; exp_q[3] = 8'h55;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (ocount !== 3'd4) begin errors++; $display("FAIL simfull_count got=%0d exp=4", ocount); end
    checks++; if (ofull !== 1'b1) begin errors++; $display("FAIL simfull_full got=%b exp=1", ofull); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ord_data !== exp_q[i]) begin errors++; $display("FAIL simfull_drain[%0d] got=%h exp=%h", i, ord_data, exp_q[i]); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL simfull_empty got=%b exp=0", ovalid); end
  endtask

  task automatic test_empty_simul;
    step(1'b1, 8'h77, 1'b1, 1'b0);
    checks++; if (ocount !== 3'd1) begin errors++; $display("FAIL simempty_count got=%0d exp=1", ocount); end
    checks++; if (ord_data !== 8'h77) begin errors++; $display("FAIL simempty_data got=%h exp=77", ord_data); end
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL simempty_valid got=%b exp=1", ovalid); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_wrap_reset;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      checks++; if (ord_data !== 8'h80 + 8'(i)) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, ord_data, 8'h80 + 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (ocount !== 3'd0) begin errors++; $display("FAIL wrap_count got=%0d exp=0", ocount); end
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    irst_n = 1'b0;
    #1;
    checks++; if (ocount !== 3'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", ocount); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", ovalid); end
    checks++; if (oovf !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got=%b exp=0", oovf); end
    #2;
    irst_n = 1'b1;
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    checks++; if (ord_data !== 8'hC3) begin errors++; $display("FAIL post_rst_data got=%h exp=c3", ord_data); end
    checks++; if (ocount !== 3'd1) begin errors++; $display("FAIL post_rst_count got=%0d exp=1", ocount); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL post_rst_empty got=%b exp=0", ovalid); end
  endtask

  initial begin
    test_reset;
    test_first_write;
    test_fill_drain;
    test_full_drop;
    test_full_simul;
    test_empty_simul;
    test_wrap_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_rd_fifo.md
BUS_RD_FIFO -- requirements
Module: bus_rd_fifo

Interface
REQ-001 The block SHALL have parameter pDATA_WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter pDEPTH, default 4, giving the number of entries; legal values are powers of two, 2 to 16.
REQ-003 The block SHALL have port iclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port irst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port iwr_en, input, 1 bit: write strobe from the producer.
REQ-006 The block SHALL have port iwr_data, input, pDATA_WIDTH bits: write data.
REQ-007 The block SHALL have port ofull, output, 1 bit: high when count equals pDEPTH.
REQ-008 The block SHALL have port ird_en, input, 1 bit: read/pop strobe from the consumer.
REQ-009 The block SHALL have port ord_data, output, pDATA_WIDTH bits: head entry, first-word-fall-through.
REQ-010 The block SHALL have port ovalid, output, 1 bit: high when count is nonzero.
REQ-011 The block SHALL have port ocount, output, $clog2(pDEPTH)+1 bits: number of stored entries.
REQ-012 The block SHALL have port iclr_ovf, input, 1 bit: clears the overflow flag.
REQ-013 The block SHALL have port oovf, output, 1 bit: sticky overflow flag.

Function
REQ-014 Storage SHALL be a circular buffer of pDEPTH words with write pointer, read pointer and count registers.
REQ-015 A write SHALL be accepted when iwr_en=1 and (ofull=0, or ird_en=1 in the same cycle); iwr_data goes to the write-pointer slot and the write pointer advances.
REQ-016 A read SHALL be accepted when ird_en=1 and ovalid=1; the read pointer advances.
REQ-017 Pointers SHALL wrap from pDEPTH-1 to 0 with no gap or stall.
REQ-018 ocount SHALL increment on an accepted write only, decrement on an accepted read only, and hold when both or neither are accepted.
REQ-019 When full with iwr_en=1 and ird_en=1, both SHALL be accepted and ocount SHALL stay at pDEPTH.
REQ-020 When empty with iwr_en=1 and ird_en=1, the read SHALL be ignored, the write accepted, and ocount SHALL become 1.
REQ-021 A write while full without a read SHALL be dropped, with storage and pointers unchanged.
REQ-022 A read while empty SHALL be ignored, with no pointer change.
REQ-023 ord_data SHALL present the read-pointer slot combinationally; the first written word SHALL appear on ord_data with ovalid=1 in the cycle after its write (write-to-valid latency 1).
REQ-024 ord_data SHALL hold its last slot value when ovalid=0; consumers SHALL ignore it then.
REQ-025 ofull and ovalid SHALL be decoded from registered ocount, with no combinational path from iwr_en or ird_en.

Reset
REQ-026 Assertion of irst_n=0 SHALL immediately clear pointers, ocount and oovf, so that ovalid=0, ofull=0 and ocount=0.
REQ-027 Storage contents SHALL NOT be reset; ord_data SHALL read slot 0 after reset, and its value is don't-care.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; the first post-reset write SHALL land in slot 0.
REQ-029 Deassertion of reset SHALL be sampled by the iclk domain; the first accepted write SHALL be on the first rising edge with irst_n=1.

Configuration
REQ-030 Macro BUS_RD_FIFO_OVF_EN defined: oovf SHALL set on any write dropped per REQ-021.
REQ-031 Macro BUS_RD_FIFO_OVF_EN defined: oovf SHALL clear on iclr_ovf=1; a simultaneous set and clear SHALL result in set.
REQ-032 Macro BUS_RD_FIFO_OVF_EN undefined: oovf SHALL be tied to 0, iclr_ovf SHALL be ignored, and no overflow register SHALL be synthesized; both ports remain present.

Verification (pDATA_WIDTH=8, pDEPTH=4)
REQ-033 The bench SHALL cover: reset, then write 0x11 -> next cycle ovalid=1, ord_data=0x11, ocount=1.
REQ-034 The bench SHALL cover: write 0x01..0x04 -> ofull=1, ocount=4; pop 4 times -> data 0x01,0x02,0x03,0x04 in order, then ovalid=0.
REQ-035 The bench SHALL cover: full, then write 0xAA with ird_en=0 -> dropped, ocount=4; with the macro defined oovf=1, otherwise oovf=0.
REQ-036 The bench SHALL cover: full, then simultaneous write 0x55 and read -> head popped, ocount=4, and 0x55 is read out last.
REQ-037 The bench SHALL cover: empty, then simultaneous write 0x77 and read -> ocount=1, ord_data=0x77.
REQ-038 The bench SHALL cover: 10 write/pop pairs across pointer wrap, then irst_n pulsed mid-stream -> ocount=0, ovalid=0, oovf=0 immediately, and the next write is read back correctly.
